// File: rtl/sram_like_arb_2x1.sv
// Two-master to one-slave sram-like arbiter: round-robin on ties, one transaction
// in flight, and a watchdog that drops a stalled data phase and flags it.
module sram_like_arb_2x1 #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic        inst_wr,
    input  logic [1:0]  inst_size,
    input  logic [31:0] inst_addr,
    input  logic [31:0] inst_wdata,
    output logic [31:0] inst_rdata,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic [31:0] data_rdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic        out_req,
    output logic        out_wr,
    output logic [1:0]  out_size,
    output logic [31:0] out_addr,
    output logic [31:0] out_wdata,
    input  logic [31:0] out_rdata,
    input  logic        out_addr_ok,
    input  logic        out_data_ok,
    output logic        owner,
    output logic        timeout_err
);
    localparam logic [15:0] LP_TIMEOUT = 16'(TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_ADDR, S_WAIT_DATA} state_t;

    state_t      r_state;
    logic        r_owner;
    logic        r_last_grant;
    logic        r_timeout_err;
    logic [15:0] r_wdog;

    logic        w_own_req;
    logic        w_addr_hs;
    logic        w_expire;

    assign w_own_req = r_owner ? data_req : inst_req;
    assign w_addr_hs = out_addr_ok & w_own_req;
    // Expires on the cycle that would bring the count up to TIMEOUT.
    assign w_expire  = (r_wdog + 16'd1) == LP_TIMEOUT;

    assign owner       = r_owner;
    assign timeout_err = r_timeout_err;

    always_comb begin
        out_req      = 1'b0;
        out_wr       = 1'b0;
        out_size     = 2'd0;
        out_addr     = 32'd0;
        out_wdata    = 32'd0;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;
        inst_rdata   = 32'd0;
        data_rdata   = 32'd0;
        if (r_state == S_WAIT_ADDR) begin
            out_req      = w_own_req;
            out_wr       = r_owner ? data_wr    : inst_wr;
            out_size     = r_owner ? data_size  : inst_size;
            out_addr     = r_owner ? data_addr  : inst_addr;
            out_wdata    = r_owner ? data_wdata : inst_wdata;
            inst_addr_ok = w_addr_hs & ~r_owner;
            data_addr_ok = w_addr_hs &  r_owner;
        end else if (r_state == S_WAIT_DATA) begin
            inst_data_ok = out_data_ok & ~r_owner;
            data_data_ok = out_data_ok &  r_owner;
            inst_rdata   = r_owner ? 32'd0 : out_rdata;
            data_rdata   = r_owner ? out_rdata : 32'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_owner       <= 1'b0;
            r_last_grant  <= 1'b0;
            r_timeout_err <= 1'b0;
            r_wdog        <= 16'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (inst_req && data_req) begin
                        r_owner      <= ~r_last_grant;
                        r_last_grant <= ~r_last_grant;
                        r_state      <= S_WAIT_ADDR;
                    end else if (inst_req) begin
                        r_owner <= 1'b0;
                        r_state <= S_WAIT_ADDR;
                    end else if (data_req) begin
                        r_owner <= 1'b1;
                        r_state <= S_WAIT_ADDR;
                    end
                end
                S_WAIT_ADDR: begin
                    if (!w_own_req) begin
                        r_state <= S_IDLE;
                    end else if (out_addr_ok) begin
                        r_wdog  <= 16'd0;
                        r_state <= S_WAIT_DATA;
                    end
                end
                S_WAIT_DATA: begin
                    // A data_ok in the expiry cycle completes normally.
                    if (out_data_ok) begin
                        r_state <= S_IDLE;
                    end else if (w_expire) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= S_IDLE;
                    end else begin
                        r_wdog <= r_wdog + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_like_arb_2x1.sv
// Bench for sram_like_arb_2x1: directed scenarios plus random traffic, all
// outputs compared every cycle against a transaction-level reference model.
module tb_sram_like_arb_2x1;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic [31:0] inst_rdata, data_rdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic        out_req, out_wr;
    logic [1:0]  out_size;
    logic [31:0] out_addr, out_wdata, out_rdata;
    logic        out_addr_ok, out_data_ok;
    logic        owner, timeout_err;

    always #5 clk = ~clk;

    sram_like_arb_2x1 #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
        .out_req(out_req), .out_wr(out_wr), .out_size(out_size),
        .out_addr(out_addr), .out_wdata(out_wdata), .out_rdata(out_rdata),
        .out_addr_ok(out_addr_ok), .out_data_ok(out_data_ok),
        .owner(owner), .timeout_err(timeout_err)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    // Reference model: one transaction at a time, described by who owns it,
    // whether its address was accepted, and how long the data phase has waited.
    bit m_busy, m_acc, m_own, m_last, m_err;
    int m_wait;

    task automatic check_outputs();
        logic       oreq, e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok;
        logic [1:0] e_size;
        logic [31:0] e_addr, e_wdata, e_ir, e_dr;
        oreq = m_own ? data_req : inst_req;
        {e_req, e_wr, e_iaok, e_daok, e_idok, e_ddok} = '0;
        e_size = '0; e_addr = '0; e_wdata = '0; e_ir = '0; e_dr = '0;
        if (m_busy && !m_acc) begin
            e_req   = oreq;
            e_wr    = m_own ? data_wr    : inst_wr;
            e_size  = m_own ? data_size  : inst_size;
            e_addr  = m_own ? data_addr  : inst_addr;
            e_wdata = m_own ? data_wdata : inst_wdata;
            if (out_addr_ok && oreq) begin
                if (m_own) e_daok = 1'b1; else e_iaok = 1'b1;
            end
        end else if (m_busy && m_acc) begin
            if (m_own) begin e_ddok = out_data_ok; e_dr = out_rdata; end
            else       begin e_idok = out_data_ok; e_ir = out_rdata; end
        end
        chk("ctl", 64'({out_req, out_wr, out_size, owner, timeout_err,
                        inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}),
                   64'({e_req, e_wr, e_size, m_own, m_err, e_iaok, e_daok, e_idok, e_ddok}));
        chk("out_bus", {out_addr, out_wdata}, {e_addr, e_wdata});
        chk("rdata", {inst_rdata, data_rdata}, {e_ir, e_dr});
        chk("ok_excl", 64'({inst_addr_ok & data_addr_ok, inst_data_ok & data_data_ok}), 64'd0);
    endtask

    task automatic model_step();
        logic oreq;
        oreq = m_own ? data_req : inst_req;
        if (rst) begin
            m_busy = 0; m_acc = 0; m_own = 0; m_last = 0; m_err = 0; m_wait = 0;
        end else if (!m_busy) begin
            if (inst_req || data_req) begin
                if (inst_req && data_req) begin m_own = !m_last; m_last = m_own; end
                else m_own = data_req;
                m_busy = 1; m_acc = 0;
            end
        end else if (!m_acc) begin
            if (!oreq) m_busy = 0;
            else if (out_addr_ok) begin m_acc = 1; m_wait = 0; end
        end else begin
            if (out_data_ok) m_busy = 0;
            else begin
                m_wait++;
                if (m_wait >= TMO) begin m_err = 1; m_busy = 0; end
            end
        end
    endtask

    task automatic tick();
        #1 check_outputs();
        model_step();
        @(posedge clk); #1;
    endtask

    task automatic idle_inputs();
        rst = 0; inst_req = 0; inst_wr = 0; inst_size = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
        out_rdata = 0; out_addr_ok = 0; out_data_ok = 0;
    endtask

    task automatic do_reset();
        idle_inputs(); rst = 1; tick(); rst = 0;
    endtask

    initial begin
        logic q_own[$];
        logic iack, dack;
        idle_inputs();
        rst = 1;
        @(posedge clk); #1;
        #1 chk("rst_state", 64'({out_req, owner, timeout_err, inst_addr_ok, data_addr_ok,
                                 inst_data_ok, data_data_ok, inst_rdata, data_rdata}), 64'd0);
        tick(); rst = 0;

        // Single inst read: grant, addr_ok at cycle 2, data at cycle 4.
        inst_req = 1; inst_addr = 32'h0000_1000; inst_size = 2; tick();
        #1 chk("grant_lat", 64'(out_req), 64'd1); tick();
        out_addr_ok = 1; #1 chk("inst_aok", 64'(inst_addr_ok), 64'd1); tick();
        inst_req = 0; out_addr_ok = 0; tick();
        out_data_ok = 1; out_rdata = 32'h1234_5678;
        #1 chk("inst_rdata", 64'({inst_data_ok, inst_rdata}), 64'({1'b1, 32'h1234_5678}));
        tick(); idle_inputs(); tick();

        // Continuous contention: round-robin order data, inst, data, inst.
        do_reset();
        inst_req = 1; data_req = 1; out_addr_ok = 1; out_data_ok = 1;
        for (int c = 0; c < 14; c++) begin
            #1 if (out_req) q_own.push_back(owner);
            tick();
        end
        chk("rr_count", 64'(q_own.size() >= 4), 64'd1);
        for (int i = 0; i < 4 && i < q_own.size(); i++)
            chk("rr_order", 64'(q_own[i]), 64'((i % 2 == 0) ? 1 : 0));

        // Data write in flight holds off a new inst request.
        do_reset();
        data_req = 1; data_wr = 1; data_addr = 32'hA0; data_wdata = 32'h55AA; tick();
        out_addr_ok = 1; tick();
        data_req = 0; inst_req = 1;
        for (int c = 0; c < 2; c++) begin
            #1 chk("holdoff", 64'(inst_addr_ok), 64'd0); tick();
        end
        out_data_ok = 1; tick();
        out_data_ok = 0; out_addr_ok = 0; tick();
        #1 chk("late_grant", 64'({out_req, owner}), 64'({1'b1, 1'b0})); tick();
        idle_inputs(); tick();

        // Watchdog expiry, then a normal transaction.
        do_reset();
        inst_req = 1; tick(); out_addr_ok = 1; tick(); inst_req = 0; out_addr_ok = 0;
        for (int c = 0; c < TMO; c++) tick();
        #1 chk("tmo_err", 64'({timeout_err, out_req}), 64'({1'b1, 1'b0}));
        inst_req = 1; tick(); out_addr_ok = 1; tick(); inst_req = 0; out_addr_ok = 0;
        out_data_ok = 1; out_rdata = 32'hCAFE;
        #1 chk("post_tmo", 64'({inst_data_ok, timeout_err}), 64'({1'b1, 1'b1})); tick();
        idle_inputs(); tick();

        // Reset mid WAIT_ADDR; a late addr_ok is not forwarded.
        do_reset();
        inst_req = 1; tick(); rst = 1; tick(); rst = 0; inst_req = 0; out_addr_ok = 1;
        #1 chk("rst_mid", 64'({out_req, inst_addr_ok, data_addr_ok, owner}), 64'd0); tick();
        idle_inputs(); tick();

        // Owner abandons its request before addr_ok.
        data_req = 1; tick(); data_req = 0; tick();
        #1 chk("drop_req", 64'({out_req, data_addr_ok}), 64'd0); tick();

        // Random traffic with occasional resets and protocol violations.
        iack = 0; dack = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            inst_req = (inst_req && !iack) ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
            data_req = (data_req && !dack) ? ($urandom_range(0, 19) != 0) : 1'($urandom_range(0, 1));
            inst_wr = 1'($urandom_range(0, 1)); data_wr = 1'($urandom_range(0, 1));
            inst_size = 2'($urandom_range(0, 2)); data_size = 2'($urandom_range(0, 2));
            inst_addr = $urandom; inst_wdata = $urandom;
            data_addr = $urandom; data_wdata = $urandom;
            out_rdata = $urandom;
            out_addr_ok = ($urandom_range(0, 1) == 1);
            out_data_ok = ($urandom_range(0, 9) < 4);
            #1 iack = inst_addr_ok; dack = data_addr_ok;
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
